multi_cycle_control: RTL and testbench

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/multi_cycle_control.sv | 146 ++++++++++++++
 tb/tb_multi_cycle_control.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// Multi-cycle datapath controller: sequences fetch/decode/execute/writeback
// states, bounds every memory wait with MEM_TIMEOUT and latches into FAULT.
module multi_cycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int ALUOP_W     = 4
) (
    input  logic               CLK,
    input  logic               Resetb,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         FuncCode,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               IRWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemToReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               SignExtend,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               Fault,
    output logic [3:0]         State
);
    localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE  = 4'd2,  S_MEMADDR = 4'd3,
                           S_MEMRD = 4'd4, S_MEMWB = 4'd5,  S_MEMWR   = 4'd6,  S_EXEC    = 4'd7,
                           S_RWB  = 4'd8,  S_IMMEXEC = 4'd9, S_IMMWB  = 4'd10, S_BRANCH  = 4'd11,
                           S_JUMP = 4'd12, S_FAULT = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_BEQ   = 6'b000100,
                           OP_ADDI  = 6'b001000, OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010,
                           OP_SLTIU = 6'b001011, OP_ANDI = 6'b001100, OP_ORI   = 6'b001101,
                           OP_XORI  = 6'b001110, OP_LUI  = 6'b001111, OP_LW    = 6'b100011,
                           OP_SW    = 6'b101011;

    logic [3:0] state, nxt;
    logic [7:0] wait_cnt;
    logic       is_mem, tmo;
    logic       is_imm, imm_se;
    logic [3:0] imm_op, op4;

    assign is_mem = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    // This wait cycle is the MEM_TIMEOUT-th one if MemReady stays low.
    assign tmo    = ({24'd0, wait_cnt} >= 32'(MEM_TIMEOUT - 1));
    assign State  = state;

    always_comb begin
        is_imm = 1'b1;
        imm_se = 1'b0;
        imm_op = 4'b0000;
        case (Opcode)
            OP_ORI:   imm_op = 4'b0001;
            OP_ADDI:  begin imm_op = 4'b0010; imm_se = 1'b1; end
            OP_ADDIU: imm_op = 4'b1000;
            OP_ANDI:  imm_op = 4'b0000;
            OP_LUI:   imm_op = 4'b1110;
            OP_SLTI:  begin imm_op = 4'b0111; imm_se = 1'b1; end
            OP_SLTIU: begin imm_op = 4'b1011; imm_se = 1'b1; end
            OP_XORI:  imm_op = 4'b1010;
            default:  is_imm = 1'b0;
        endcase
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   nxt = S_FETCH;
            S_FETCH:  if (MemReady) nxt = S_DECODE; else if (tmo) nxt = S_FAULT;
            S_DECODE: begin
                if (Opcode == OP_LW || Opcode == OP_SW) nxt = S_MEMADDR;
                else if (Opcode == OP_RTYPE)            nxt = S_EXEC;
                else if (is_imm)                        nxt = S_IMMEXEC;
                else if (Opcode == OP_BEQ)              nxt = S_BRANCH;
                else if (Opcode == OP_J)                nxt = S_JUMP;
                else                                    nxt = S_FAULT;
            end
            S_MEMADDR: begin
                if (Opcode == OP_LW)      nxt = S_MEMRD;
                else if (Opcode == OP_SW) nxt = S_MEMWR;
                else                      nxt = S_FAULT;
            end
            S_MEMRD:  if (MemReady) nxt = S_MEMWB; else if (tmo) nxt = S_FAULT;
            S_MEMWR:  if (MemReady) nxt = S_FETCH; else if (tmo) nxt = S_FAULT;
            S_MEMWB, S_RWB, S_IMMWB, S_BRANCH, S_JUMP: nxt = S_FETCH;
            S_EXEC:    nxt = S_RWB;
            S_IMMEXEC: nxt = S_IMMWB;
            S_FAULT:   nxt = S_FAULT;
            default:   nxt = S_FAULT;
        endcase
    end

    always_ff @(posedge CLK or negedge Resetb) begin
        if (!Resetb) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state <= nxt;
            // Any state change clears the counter, so each memory state starts fresh.
            if (nxt != state)
                wait_cnt <= 8'd0;
            else if (is_mem && !MemReady)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0; IRWrite = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; MemToReg = 1'b0; RegDst = 1'b0;
        RegWrite = 1'b0; SignExtend = 1'b0; Fault = 1'b0;
        ALUSrcA = 2'b00; ALUSrcB = 2'b00; PCSource = 2'b00; op4 = 4'b0000;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1; ALUSrcB = 2'b01; op4 = 4'b0010;
                IRWrite = MemReady; PCWrite = MemReady;
            end
            S_DECODE:  begin ALUSrcB = 2'b11; op4 = 4'b0010; SignExtend = 1'b1; end
            S_MEMADDR: begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; op4 = 4'b0010; SignExtend = 1'b1; end
            S_MEMRD:   begin MemRead = 1'b1; IorD = 1'b1; end
            S_MEMWR:   begin MemWrite = 1'b1; IorD = 1'b1; end
            S_MEMWB:   begin RegWrite = 1'b1; MemToReg = 1'b1; end
            S_EXEC: begin
                op4 = 4'b1111;
                ALUSrcA = (FuncCode == 6'b000000 || FuncCode == 6'b000010 ||
                           FuncCode == 6'b000011) ? 2'b10 : 2'b01;
            end
            S_RWB: begin RegWrite = 1'b1; RegDst = 1'b1; end
            S_IMMEXEC, S_IMMWB: begin
                // Writeback keeps the execute controls so the ALU result stays valid.
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; op4 = imm_op; SignExtend = imm_se;
                RegWrite = (state == S_IMMWB);
            end
            S_BRANCH: begin
                ALUSrcA = 2'b01; op4 = 4'b0110; PCWriteCond = 1'b1; PCSource = 2'b01;
            end
            S_JUMP:  begin PCWrite = 1'b1; PCSource = 2'b10; end
            S_FAULT: Fault = 1'b1;
            default: ;
        endcase
    end

    assign ALUOp = ALUOP_W'(op4);
endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: per-cycle stimulus and expected
// state/control vectors are queued, then replayed and compared each cycle.
module tb_multi_cycle_control;
    logic       CLK = 1'b0, Resetb = 1'b0, MemReady = 1'b0;
    logic [5:0] Opcode = 6'd0, FuncCode = 6'd0;
    logic PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemToReg, RegDst, RegWrite, SignExtend, Fault;
    logic [1:0] ALUSrcA, ALUSrcB, PCSource;
    logic [3:0] ALUOp, State;
    logic [20:0] obs;

    int n_chk = 0, n_fail = 0;

    multi_cycle_control #(.MEM_TIMEOUT(4), .ALUOP_W(4)) dut (
        .CLK(CLK), .Resetb(Resetb), .Opcode(Opcode), .FuncCode(FuncCode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .IRWrite(IRWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .SignExtend(SignExtend), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALUOp(ALUOp), .Fault(Fault), .State(State)
    );

    always #5 CLK = ~CLK;

    // Flags: pcw pcwc iord irw mr mw m2r rd rw se | srcA | srcB | pcsrc | aluop | fault
    assign obs = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemToReg, RegDst,
                  RegWrite, SignExtend, ALUSrcA, ALUSrcB, PCSource, ALUOp, Fault};

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADDR = 4'd3,
                           S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7,
                           S_RWB = 4'd8, S_IMMEXEC = 4'd9, S_IMMWB = 4'd10, S_BRANCH = 4'd11,
                           S_JUMP = 4'd12, S_FAULT = 4'd13;

    localparam logic [20:0] C_FETCH_R = {10'b1001100000, 2'b00, 2'b01, 2'b00, 4'b0010, 1'b0};
    localparam logic [20:0] C_FETCH_W = {10'b0000100000, 2'b00, 2'b01, 2'b00, 4'b0010, 1'b0};
    localparam logic [20:0] C_DECODE  = {10'b0000000001, 2'b00, 2'b11, 2'b00, 4'b0010, 1'b0};
    localparam logic [20:0] C_MEMADDR = {10'b0000000001, 2'b01, 2'b10, 2'b00, 4'b0010, 1'b0};
    localparam logic [20:0] C_MEMRD   = {10'b0010100000, 11'd0};
    localparam logic [20:0] C_MEMWR   = {10'b0010010000, 11'd0};
    localparam logic [20:0] C_MEMWB   = {10'b0000001010, 11'd0};
    localparam logic [20:0] C_EXEC    = {10'b0000000000, 2'b01, 2'b00, 2'b00, 4'b1111, 1'b0};
    localparam logic [20:0] C_EXEC_SH = {10'b0000000000, 2'b10, 2'b00, 2'b00, 4'b1111, 1'b0};
    localparam logic [20:0] C_RWB     = {10'b0000000110, 11'd0};
    localparam logic [20:0] C_BRANCH  = {10'b0100000000, 2'b01, 2'b00, 2'b01, 4'b0110, 1'b0};
    localparam logic [20:0] C_JUMP    = {10'b1000000000, 2'b00, 2'b00, 2'b10, 4'b0000, 1'b0};
    localparam logic [20:0] C_FAULT   = 21'd1;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_BAD = 6'b111111;

    typedef struct {
        logic        mr;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [3:0]  st;
        logic [20:0] ctl;
    } rec_t;
    rec_t sb[$];
    rec_t r;

    function automatic logic [20:0] imm_ctl(input logic [3:0] op, input logic se, input logic wb);
        return {8'b0, wb, se, 2'b01, 2'b10, 2'b00, op, 1'b0};
    endfunction

    task automatic add(input logic mr, input logic [5:0] opc, input logic [5:0] fn,
                       input logic [3:0] st, input logic [20:0] ctl);
        rec_t e;
        e.mr = mr; e.opc = opc; e.fn = fn; e.st = st; e.ctl = ctl;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge CLK); Resetb = 1'b0;
        @(negedge CLK); Resetb = 1'b1;
    endtask

    task automatic test_reset();
        Resetb = 1'b0; MemReady = 1'b1; Opcode = OP_LW;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK); #1;
            n_chk++;
            if ({State, obs} !== {S_IDLE, 21'd0}) begin
                n_fail++;
                $display("FAIL reset_hold: state=%0d ctl=%b expected state=%0d ctl=%b", State, obs, S_IDLE, 21'd0);
            end
        end
        @(negedge CLK); Resetb = 1'b1;
        @(posedge CLK); #1;
        n_chk++;
        if (State !== S_FETCH) begin
            n_fail++;
            $display("FAIL reset_first_fetch: state=%0d expected %0d", State, S_FETCH);
        end
    endtask

    task automatic test_rtype();
        do_reset();
        add(1, OP_R, 6'b100000, S_FETCH, C_FETCH_R); add(1, OP_R, 6'b100000, S_DECODE, C_DECODE);
        add(1, OP_R, 6'b100000, S_EXEC, C_EXEC);     add(1, OP_R, 6'b100000, S_RWB, C_RWB);
        add(1, OP_R, 6'b000000, S_FETCH, C_FETCH_R); add(1, OP_R, 6'b000000, S_DECODE, C_DECODE);
        add(1, OP_R, 6'b000000, S_EXEC, C_EXEC_SH);  add(1, OP_R, 6'b000000, S_RWB, C_RWB);
        add(1, OP_R, 6'b000011, S_FETCH, C_FETCH_R); add(1, OP_R, 6'b000011, S_DECODE, C_DECODE);
        add(1, OP_R, 6'b000011, S_EXEC, C_EXEC_SH);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            @(negedge CLK); MemReady = r.mr; Opcode = r.opc; FuncCode = r.fn; #1;
            n_chk++;
            if ({State, obs} !== {r.st, r.ctl}) begin
                n_fail++;
                $display("FAIL rtype: state=%0d ctl=%b expected state=%0d ctl=%b", State, obs, r.st, r.ctl);
            end
        end
    endtask

    task automatic test_mem();
        do_reset();
        add(1, OP_LW, 0, S_FETCH, C_FETCH_R); add(1, OP_LW, 0, S_DECODE, C_DECODE);
        add(1, OP_LW, 0, S_MEMADDR, C_MEMADDR);
        for (int i = 0; i < 3; i++) add(0, OP_LW, 0, S_MEMRD, C_MEMRD);
        add(1, OP_LW, 0, S_MEMRD, C_MEMRD);   add(1, OP_LW, 0, S_MEMWB, C_MEMWB);
        add(1, OP_SW, 0, S_FETCH, C_FETCH_R); add(1, OP_SW, 0, S_DECODE, C_DECODE);
        add(1, OP_SW, 0, S_MEMADDR, C_MEMADDR); add(0, OP_SW, 0, S_MEMWR, C_MEMWR);
        add(1, OP_SW, 0, S_MEMWR, C_MEMWR);   add(1, OP_J, 0, S_FETCH, C_FETCH_R);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            @(negedge CLK); MemReady = r.mr; Opcode = r.opc; FuncCode = r.fn; #1;
            n_chk++;
            if ({State, obs} !== {r.st, r.ctl}) begin
                n_fail++;
                $display("FAIL mem: state=%0d ctl=%b expected state=%0d ctl=%b", State, obs, r.st, r.ctl);
            end
        end
    endtask

    task automatic test_imm();
        logic [5:0] opcs [6] = '{6'b001010, 6'b001100, 6'b001111, 6'b001001, 6'b001101, 6'b001011};
        logic [3:0] ops  [6] = '{4'b0111,   4'b0000,   4'b1110,   4'b1000,   4'b0001,   4'b1011};
        logic       ses  [6] = '{1'b1,      1'b0,      1'b0,      1'b0,      1'b0,      1'b1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            add(1, opcs[i], 0, S_FETCH, C_FETCH_R);
            add(1, opcs[i], 0, S_DECODE, C_DECODE);
            add(0, opcs[i], 0, S_IMMEXEC, imm_ctl(ops[i], ses[i], 1'b0));
            add(0, opcs[i], 0, S_IMMWB, imm_ctl(ops[i], ses[i], 1'b1));
        end
        while (sb.size() > 0) begin
            r = sb.pop_front();
            @(negedge CLK); MemReady = r.mr; Opcode = r.opc; FuncCode = r.fn; #1;
            n_chk++;
            if ({State, obs} !== {r.st, r.ctl}) begin
                n_fail++;
                $display("FAIL imm: op=%b state=%0d ctl=%b expected state=%0d ctl=%b", r.opc, State, obs, r.st, r.ctl);
            end
        end
    endtask

    task automatic test_branch_jump();
        do_reset();
        add(1, OP_BEQ, 0, S_FETCH, C_FETCH_R); add(1, OP_BEQ, 0, S_DECODE, C_DECODE);
        add(1, OP_BEQ, 0, S_BRANCH, C_BRANCH);
        add(1, OP_J, 0, S_FETCH, C_FETCH_R);   add(1, OP_J, 0, S_DECODE, C_DECODE);
        add(0, OP_J, 0, S_JUMP, C_JUMP);
        // Three fetch waits sit one short of the timeout of 4.
        for (int i = 0; i < 3; i++) add(0, OP_J, 0, S_FETCH, C_FETCH_W);
        add(1, OP_J, 0, S_FETCH, C_FETCH_R);   add(1, OP_J, 0, S_DECODE, C_DECODE);
        add(1, OP_J, 0, S_JUMP, C_JUMP);       add(1, OP_J, 0, S_FETCH, C_FETCH_R);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            @(negedge CLK); MemReady = r.mr; Opcode = r.opc; FuncCode = r.fn; #1;
            n_chk++;
            if ({State, obs} !== {r.st, r.ctl}) begin
                n_fail++;
                $display("FAIL branch_jump: state=%0d ctl=%b expected state=%0d ctl=%b", State, obs, r.st, r.ctl);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 4; i++) add(0, OP_R, 0, S_FETCH, C_FETCH_W);
        add(1, OP_R, 0, S_FAULT, C_FAULT); add(1, OP_LW, 0, S_FAULT, C_FAULT);
        add(0, OP_J, 0, S_FAULT, C_FAULT);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            @(negedge CLK); MemReady = r.mr; Opcode = r.opc; FuncCode = r.fn; #1;
            n_chk++;
            if ({State, obs} !== {r.st, r.ctl}) begin
                n_fail++;
                $display("FAIL timeout: state=%0d ctl=%b expected state=%0d ctl=%b", State, obs, r.st, r.ctl);
            end
        end
        Resetb = 1'b0; #1;
        n_chk++;
        if ({State, Fault, obs} !== {S_IDLE, 1'b0, 21'd0}) begin
            n_fail++;
            $display("FAIL timeout_reset: state=%0d fault=%b ctl=%b expected state=0 fault=0 ctl=0", State, Fault, obs);
        end
        @(negedge CLK); Resetb = 1'b1;
    endtask

    task automatic test_bad_opcode();
        do_reset();
        add(1, OP_BAD, 0, S_FETCH, C_FETCH_R); add(1, OP_BAD, 0, S_DECODE, C_DECODE);
        for (int i = 0; i < 3; i++) add(1, OP_SW, 0, S_FAULT, C_FAULT);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            @(negedge CLK); MemReady = r.mr; Opcode = r.opc; FuncCode = r.fn; #1;
            n_chk++;
            if ({State, obs} !== {r.st, r.ctl}) begin
                n_fail++;
                $display("FAIL bad_opcode: state=%0d ctl=%b expected state=%0d ctl=%b", State, obs, r.st, r.ctl);
            end
        end
    endtask

    task automatic test_reset_memwr();
        do_reset();
        add(1, OP_SW, 0, S_FETCH, C_FETCH_R); add(1, OP_SW, 0, S_DECODE, C_DECODE);
        add(1, OP_SW, 0, S_MEMADDR, C_MEMADDR);
        add(0, OP_SW, 0, S_MEMWR, C_MEMWR);   add(0, OP_SW, 0, S_MEMWR, C_MEMWR);
        while (sb.size() > 0) begin
            r = sb.pop_front();
            @(negedge CLK); MemReady = r.mr; Opcode = r.opc; FuncCode = r.fn; #1;
            n_chk++;
            if ({State, obs} !== {r.st, r.ctl}) begin
                n_fail++;
                $display("FAIL reset_memwr_pre: state=%0d ctl=%b expected state=%0d ctl=%b", State, obs, r.st, r.ctl);
            end
        end
        // Mid-cycle, away from any clock edge: only the async path can clear it.
        #1 Resetb = 1'b0; #1;
        n_chk++;
        if (MemWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_memwr_we: MemWrite=%b expected 0", MemWrite);
        end
        n_chk++;
        if ({State, obs} !== {S_IDLE, 21'd0}) begin
            n_fail++;
            $display("FAIL reset_memwr_state: state=%0d ctl=%b expected state=0 ctl=0", State, obs);
        end
        @(negedge CLK); Resetb = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_mem();
        test_imm();
        test_branch_jump();
        test_timeout();
        test_bad_opcode();
        test_reset_memwr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
